// File: rtl/turf_acknack_pkg.sv
// Shared constants for the ack/nack filter: FSM state codes, check masks, response length.
// Combinational helpers only; no latency, no flow control.
package turf_acknack_pkg;

    localparam int          OPEN_BIT        = 62;
    localparam logic [63:0] ACK_CHECK_BITS  = 64'h800000FF_FFF00000;
    localparam logic [63:0] NACK_CHECK_BITS = 64'h000000FF_FFFFFFFF;
    localparam logic [15:0] RESP_LEN        = 16'd24;

    localparam logic [3:0] ST_IDLE         = 4'd0;
    localparam logic [3:0] ST_CHECK        = 4'd1;
    localparam logic [3:0] ST_WRITE_DATA   = 4'd2;
    localparam logic [3:0] ST_SKIP_ONE     = 4'd3;
    localparam logic [3:0] ST_DRAIN        = 4'd4;
    localparam logic [3:0] ST_DUMP         = 4'd5;
    localparam logic [3:0] ST_WRITE_HEADER = 4'd6;
    localparam logic [3:0] ST_RESP0        = 4'd7;
    localparam logic [3:0] ST_RESP1        = 4'd8;

    // The open bit is owned by the response path, so it never takes part in a compare.
    function automatic logic [63:0] mask_word(input logic [63:0] w, input logic [63:0] bits);
        return w & bits & ~(64'd1 << OPEN_BIT);
    endfunction

endpackage

// File: rtl/turf_acknack_hist.sv
// DEPTH-entry ring of accepted masked words with a parallel match against cmp_dat.
// Match is combinational (zero latency); writes take one cycle; clr beats a same-cycle write.
module turf_acknack_hist #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             clr,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic [WIDTH-1:0] cmp_dat,
    output logic             match
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] entry [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge aclk) begin
        if (areset || clr) begin
            valid  <= '0;
            wr_ptr <= '0;
        end else if (wr_vld) begin
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        end
    end

    // Stale data is harmless once its valid bit is down, so the payload is not reset.
    always_ff @(posedge aclk) begin
        if (wr_vld) entry[wr_ptr] <= wr_dat;
    end

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entry[i] == cmp_dat)) match = 1'b1;
        end
    end

endmodule

// File: rtl/turf_acknack_filter.sv
// Filters ack/nack request qwords against recent history, emits one acknack per accepted qword and a 2-beat UDP reply.
// Decision in one CHECK cycle; payload tready follows m_acknack_tready while an acknack is offered, reply stalls on m_udp* tready.
module turf_acknack_filter
    import turf_acknack_pkg::*;
#(
    parameter logic [63:0] CHECK_BITS  = ACK_CHECK_BITS,
    parameter int          HIST_DEPTH  = 4,
    parameter int          MAX_ENTRIES = 16
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        event_open_i,
    input  logic [9:0]  nfragment_count_i,
    input  logic [63:0] s_udphdr_tdata,
    input  logic        s_udphdr_tvalid,
    output logic        s_udphdr_tready,
    input  logic [63:0] s_udpdata_tdata,
    input  logic [7:0]  s_udpdata_tkeep,
    input  logic        s_udpdata_tlast,
    input  logic        s_udpdata_tvalid,
    output logic        s_udpdata_tready,
    output logic [63:0] m_udphdr_tdata,
    output logic        m_udphdr_tvalid,
    input  logic        m_udphdr_tready,
    output logic [63:0] m_udpdata_tdata,
    output logic [7:0]  m_udpdata_tkeep,
    output logic        m_udpdata_tlast,
    output logic        m_udpdata_tvalid,
    input  logic        m_udpdata_tready,
    output logic [47:0] m_acknack_tdata,
    output logic        m_acknack_tvalid,
    input  logic        m_acknack_tready
);

    localparam logic [7:0] MAX_E = 8'(MAX_ENTRIES);

    logic [3:0]  state;
    logic [31:0] ip;
    logic [15:0] port;
    logic [15:0] accepted, dup, dropped;
    logic [7:0]  examined;
    logic [63:0] last_store;
    logic        full_nack;
    logic [10:0] nack_count;
    logic        open_q, rst_q, blk;
    logic        hdr_hs, dat_hs, hist_match, hist_clr, hist_wr;
    logic [63:0] masked;
    logic        hdr_len_unused;

    assign masked         = mask_word(s_udpdata_tdata, CHECK_BITS);
    assign blk            = areset || rst_q;
    assign hdr_hs         = s_udphdr_tvalid && s_udphdr_tready;
    assign dat_hs         = s_udpdata_tvalid && s_udpdata_tready;
    assign hist_clr       = open_q && !event_open_i;
    assign hist_wr        = (state == ST_WRITE_DATA) && dat_hs;
    assign hdr_len_unused = ^s_udphdr_tdata[15:0];

    turf_acknack_hist #(.DEPTH(HIST_DEPTH), .WIDTH(64)) u_hist (
        .aclk    (aclk),
        .areset  (areset),
        .clr     (hist_clr),
        .wr_vld  (hist_wr),
        .wr_dat  (masked),
        .cmp_dat (masked),
        .match   (hist_match)
    );

    assign m_acknack_tdata = {s_udpdata_tdata[63], full_nack, 3'b000, nack_count, s_udpdata_tdata[31:0]};
    assign m_udphdr_tdata  = {ip, port, RESP_LEN};

    // Handshake outputs stay quiet through reset and the cycle after it.
    always_comb begin
        s_udphdr_tready  = 1'b0;
        s_udpdata_tready = 1'b0;
        m_acknack_tvalid = 1'b0;
        m_udphdr_tvalid  = 1'b0;
        m_udpdata_tvalid = 1'b0;
        m_udpdata_tdata  = '0;
        m_udpdata_tkeep  = 8'h00;
        m_udpdata_tlast  = 1'b0;
        if (!blk) begin
            case (state)
                ST_IDLE:       s_udphdr_tready = 1'b1;
                ST_WRITE_DATA: begin
                    m_acknack_tvalid = 1'b1;
                    s_udpdata_tready = m_acknack_tready;
                end
                ST_SKIP_ONE, ST_DRAIN, ST_DUMP: s_udpdata_tready = 1'b1;
                ST_WRITE_HEADER: m_udphdr_tvalid = 1'b1;
                ST_RESP0: begin
                    m_udpdata_tvalid = 1'b1;
                    m_udpdata_tdata  = last_store | (64'(event_open_i) << OPEN_BIT);
                    m_udpdata_tkeep  = 8'hFF;
                end
                ST_RESP1: begin
                    m_udpdata_tvalid = 1'b1;
                    m_udpdata_tdata  = {accepted, dup, dropped, 8'h00, 8'(HIST_DEPTH)};
                    m_udpdata_tkeep  = 8'hFF;
                    m_udpdata_tlast  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        rst_q <= areset;
        if (areset) begin
            open_q     <= 1'b0;
            nack_count <= '0;
        end else begin
            open_q <= event_open_i;
            if (event_open_i && !open_q) nack_count <= {1'b0, nfragment_count_i} + 11'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= ST_IDLE;
            ip         <= '0;
            port       <= '0;
            accepted   <= '0;
            dup        <= '0;
            dropped    <= '0;
            examined   <= '0;
            last_store <= '0;
            full_nack  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (hdr_hs) begin
                    ip       <= s_udphdr_tdata[63:32];
                    port     <= s_udphdr_tdata[31:16];
                    accepted <= '0;
                    dup      <= '0;
                    dropped  <= '0;
                    examined <= '0;
                    state    <= ST_CHECK;
                end
                ST_CHECK: if (s_udpdata_tvalid) begin
                    full_nack <= (s_udpdata_tdata[19:0] == 20'hFFFFF);
                    if (s_udpdata_tkeep != 8'hFF && examined == 8'd0) state <= ST_DUMP;
                    else if (s_udpdata_tkeep != 8'hFF)                state <= ST_DRAIN;
                    else if (!event_open_i)                           state <= ST_DRAIN;
                    else if (examined == MAX_E)                       state <= ST_DRAIN;
                    else if (hist_match)                              state <= ST_SKIP_ONE;
                    else                                              state <= ST_WRITE_DATA;
                end
                ST_WRITE_DATA: if (dat_hs) begin
                    accepted   <= accepted + 16'd1;
                    examined   <= examined + 8'd1;
                    last_store <= masked;
                    state      <= s_udpdata_tlast ? ST_WRITE_HEADER : ST_CHECK;
                end
                ST_SKIP_ONE: if (dat_hs) begin
                    dup      <= dup + 16'd1;
                    examined <= examined + 8'd1;
                    state    <= s_udpdata_tlast ? ST_WRITE_HEADER : ST_CHECK;
                end
                ST_DRAIN: if (dat_hs) begin
                    if (dropped != 16'hFFFF) dropped <= dropped + 16'd1;
                    if (s_udpdata_tlast) state <= ST_WRITE_HEADER;
                end
                ST_DUMP:         if (dat_hs && s_udpdata_tlast) state <= ST_IDLE;
                ST_WRITE_HEADER: if (m_udphdr_tvalid && m_udphdr_tready) state <= ST_RESP0;
                ST_RESP0:        if (m_udpdata_tvalid && m_udpdata_tready) state <= ST_RESP1;
                ST_RESP1:        if (m_udpdata_tvalid && m_udpdata_tready) state <= ST_IDLE;
                default:         state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_turf_acknack_filter.sv
// Directed bench for turf_acknack_filter (HIST_DEPTH=4, MAX_ENTRIES=2) with hand-computed expectations.
module tb_turf_acknack_filter;

    logic        aclk = 1'b0;
    logic        areset;
    logic        event_open_i;
    logic [9:0]  nfragment_count_i;
    logic [63:0] s_udphdr_tdata;
    logic        s_udphdr_tvalid, s_udphdr_tready;
    logic [63:0] s_udpdata_tdata;
    logic [7:0]  s_udpdata_tkeep;
    logic        s_udpdata_tlast, s_udpdata_tvalid, s_udpdata_tready;
    logic [63:0] m_udphdr_tdata;
    logic        m_udphdr_tvalid, m_udphdr_tready;
    logic [63:0] m_udpdata_tdata;
    logic [7:0]  m_udpdata_tkeep;
    logic        m_udpdata_tlast, m_udpdata_tvalid, m_udpdata_tready;
    logic [47:0] m_acknack_tdata;
    logic        m_acknack_tvalid, m_acknack_tready;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] HDR_IN  = 64'h0A000001_1234_0010;
    localparam logic [63:0] HDR_EXP = 64'h0A000001_1234_0018;

    logic [63:0] hdr_q [$];
    logic [63:0] dat_q [$];
    logic [8:0]  kl_q  [$];
    logic [47:0] ak_q  [$];
    logic [63:0] pkt   [8];

    always #5 aclk = ~aclk;

    turf_acknack_filter #(.HIST_DEPTH(4), .MAX_ENTRIES(2)) dut (
        .aclk              (aclk),
        .areset            (areset),
        .event_open_i      (event_open_i),
        .nfragment_count_i (nfragment_count_i),
        .s_udphdr_tdata    (s_udphdr_tdata),
        .s_udphdr_tvalid   (s_udphdr_tvalid),
        .s_udphdr_tready   (s_udphdr_tready),
        .s_udpdata_tdata   (s_udpdata_tdata),
        .s_udpdata_tkeep   (s_udpdata_tkeep),
        .s_udpdata_tlast   (s_udpdata_tlast),
        .s_udpdata_tvalid  (s_udpdata_tvalid),
        .s_udpdata_tready  (s_udpdata_tready),
        .m_udphdr_tdata    (m_udphdr_tdata),
        .m_udphdr_tvalid   (m_udphdr_tvalid),
        .m_udphdr_tready   (m_udphdr_tready),
        .m_udpdata_tdata   (m_udpdata_tdata),
        .m_udpdata_tkeep   (m_udpdata_tkeep),
        .m_udpdata_tlast   (m_udpdata_tlast),
        .m_udpdata_tvalid  (m_udpdata_tvalid),
        .m_udpdata_tready  (m_udpdata_tready),
        .m_acknack_tdata   (m_acknack_tdata),
        .m_acknack_tvalid  (m_acknack_tvalid),
        .m_acknack_tready  (m_acknack_tready)
    );

    // Inputs change 1 time unit after posedge, so negedge shows what the next posedge will transfer.
    always @(negedge aclk) begin
        if (m_acknack_tvalid && m_acknack_tready) ak_q.push_back(m_acknack_tdata);
        if (m_udphdr_tvalid && m_udphdr_tready)   hdr_q.push_back(m_udphdr_tdata);
        if (m_udpdata_tvalid && m_udpdata_tready) begin
            dat_q.push_back(m_udpdata_tdata);
            kl_q.push_back({m_udpdata_tkeep, m_udpdata_tlast});
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_hdr(input logic [63:0] h);
        int t = 0;
        @(posedge aclk); #1;
        s_udphdr_tdata  = h;
        s_udphdr_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_udphdr_tready && t < 200) begin t++; @(negedge aclk); end
        if (!s_udphdr_tready) chk("hdr_timeout", 64'(s_udphdr_tready), 64'd1);
        @(posedge aclk); #1;
        s_udphdr_tvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int t = 0;
        @(posedge aclk); #1;
        s_udpdata_tdata  = d;
        s_udpdata_tkeep  = k;
        s_udpdata_tlast  = l;
        s_udpdata_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_udpdata_tready && t < 200) begin t++; @(negedge aclk); end
        if (!s_udpdata_tready) chk("beat_timeout", 64'(s_udpdata_tready), 64'd1);
        @(posedge aclk); #1;
        s_udpdata_tvalid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [63:0] r0, input logic [63:0] r1);
        int t = 0;
        while (dat_q.size() < 2 && t < 300) begin @(negedge aclk); t++; end
        if (dat_q.size() < 2) chk({tag, "_timeout"}, 64'(dat_q.size()), 64'd2);
        else begin
            chk({tag, "_hdr"},   hdr_q.pop_front(), HDR_EXP);
            chk({tag, "_r0"},    dat_q.pop_front(), r0);
            chk({tag, "_r0_kl"}, 64'(kl_q.pop_front()), 64'h1FE);
            chk({tag, "_r1"},    dat_q.pop_front(), r1);
            chk({tag, "_r1_kl"}, 64'(kl_q.pop_front()), 64'h1FF);
        end
    endtask

    task automatic expect_ak(input string tag, input int n, input logic [47:0] exp);
        chk({tag, "_ak_n"}, 64'(ak_q.size()), 64'(n));
        while (ak_q.size() > 0) chk({tag, "_ak"}, 64'(ak_q.pop_front()), 64'(exp));
    endtask

    task automatic run_pkt(input string tag, input int n, input logic [63:0] r0, input logic [63:0] r1,
                           input int nak, input logic [47:0] akexp);
        send_hdr(HDR_IN);
        for (int i = 0; i < n; i++) send_beat(pkt[i], 8'hFF, 1'(i == n - 1));
        expect_resp(tag, r0, r1);
        expect_ak(tag, nak, akexp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        areset            = 1'b1;
        event_open_i      = 1'b0;
        nfragment_count_i = 10'd5;
        s_udphdr_tdata    = '0;
        s_udphdr_tvalid   = 1'b0;
        s_udpdata_tdata   = '0;
        s_udpdata_tkeep   = 8'h00;
        s_udpdata_tlast   = 1'b0;
        s_udpdata_tvalid  = 1'b0;
        m_udphdr_tready   = 1'b1;
        m_udpdata_tready  = 1'b1;
        m_acknack_tready  = 1'b1;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_hdr_rdy", 64'(s_udphdr_tready), 64'd0);
        chk("rst_vld", 64'({m_acknack_tvalid, m_udphdr_tvalid, m_udpdata_tvalid, s_udpdata_tready}), 64'd0);
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        chk("rst1_hdr_rdy", 64'(s_udphdr_tready), 64'd0);
        chk("rst1_vld", 64'({m_acknack_tvalid, m_udphdr_tvalid, m_udpdata_tvalid}), 64'd0);
        @(negedge aclk);
        chk("idle_hdr_rdy", 64'(s_udphdr_tready), 64'd1);

        @(posedge aclk); #1 event_open_i = 1'b1;
        repeat (2) @(posedge aclk);

        // First accept, then exact repeat is a duplicate.
        pkt[0] = 64'h80000012_34500000;
        run_pkt("first", 1, 64'hC0000012_34500000, 64'h0001_0000_0000_0004, 1, 48'h8006_34500000);
        run_pkt("repeat", 1, 64'hC0000012_34500000, 64'h0000_0001_0000_0004, 0, 48'h0);

        // Five distinct words roll the 4-deep history, so the first one is new again.
        pkt[0] = 64'h000000A1_000FFFFF;
        run_pkt("roll1", 1, 64'h400000A1_00000000, 64'h0001_0000_0000_0004, 1, 48'h4006_000FFFFF);
        for (int i = 2; i <= 5; i++) begin
            pkt[0] = {32'h000000A0 + 32'(i), 32'h0};
            run_pkt("roll", 1, {32'h400000A0 + 32'(i), 32'h0}, 64'h0001_0000_0000_0004, 1, 48'h0006_00000000);
        end
        pkt[0] = 64'h000000A1_000FFFFF;
        run_pkt("roll1_again", 1, 64'h400000A1_00000000, 64'h0001_0000_0000_0004, 1, 48'h4006_000FFFFF);

        // Bit 62 and unchecked low bits do not defeat duplicate detection.
        pkt[0] = 64'h400000A5_00000000;
        pkt[1] = 64'h000000A4_00001234;
        run_pkt("mask_dup", 2, 64'h400000A1_00000000, 64'h0000_0002_0000_0004, 0, 48'h0);

        // Only MAX_ENTRIES qwords are examined; the rest are dropped.
        for (int i = 1; i <= 4; i++) pkt[i-1] = {32'h000000B0 + 32'(i), 32'h0};
        run_pkt("max_ent", 4, 64'h400000B2_00000000, 64'h0002_0000_0002_0004, 2, 48'h0006_00000000);

        // Acknack backpressure must hold the payload beat.
        m_acknack_tready = 1'b0;
        fork
            begin
                send_hdr(HDR_IN);
                send_beat(64'h000000C1_00000000, 8'hFF, 1'b1);
            end
            begin
                repeat (10) begin
                    @(negedge aclk);
                    chk("bp_s_rdy", 64'(s_udpdata_tready), 64'd0);
                end
                chk("bp_ak_vld", 64'(m_acknack_tvalid), 64'd1);
                @(posedge aclk); #1 m_acknack_tready = 1'b1;
            end
        join
        expect_resp("bp", 64'h400000C1_00000000, 64'h0001_0000_0000_0004);
        expect_ak("bp", 1, 48'h0006_00000000);

        // Event closed: everything dropped, open bit clear, history wiped.
        @(posedge aclk); #1 event_open_i = 1'b0;
        repeat (2) @(posedge aclk);
        pkt[0] = 64'h000000C1_00000000;
        run_pkt("closed", 1, 64'h000000C1_00000000, 64'h0000_0000_0001_0004, 0, 48'h0);

        @(posedge aclk); #1;
        nfragment_count_i = 10'h3FF;
        event_open_i      = 1'b1;
        repeat (2) @(posedge aclk);
        run_pkt("reopen", 1, 64'h400000C1_00000000, 64'h0001_0000_0000_0004, 1, 48'h0400_00000000);

        // Short first beat is dumped with no reply at all.
        send_hdr(HDR_IN);
        send_beat(64'h00000000_12345678, 8'h0F, 1'b1);
        repeat (20) @(negedge aclk);
        chk("dump_hdr_n", 64'(hdr_q.size()), 64'd0);
        chk("dump_dat_n", 64'(dat_q.size()), 64'd0);
        chk("dump_ak_n",  64'(ak_q.size()),  64'd0);

        // Reset mid-packet abandons it and empties history.
        send_hdr(HDR_IN);
        send_beat(64'h000000D1_00000000, 8'hFF, 1'b0);
        areset = 1'b1;
        @(negedge aclk);
        chk("mid_rst_hdr_rdy", 64'(s_udphdr_tready), 64'd0);
        chk("mid_rst_dat_rdy", 64'(s_udpdata_tready), 64'd0);
        @(posedge aclk);
        @(posedge aclk); #1 areset = 1'b0;
        repeat (3) @(posedge aclk);
        chk("mid_rst_no_resp", 64'(hdr_q.size() + dat_q.size()), 64'd0);
        expect_ak("mid_rst_first", 1, 48'h0400_00000000);
        pkt[0] = 64'h000000D1_00000000;
        run_pkt("mid_rst_retry", 1, 64'h400000D1_00000000, 64'h0001_0000_0000_0004, 1, 48'h0400_00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
